// File: rtl/pulse_rx_pkg.sv
// Shared types and constants for the pulse receiver: FSM states, irq bit
// positions, buffer geometry, register addresses and symbol encoding.
package pulse_rx_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } rx_state_e;

  localparam int unsigned IRQ_SYMBOL   = 0;
  localparam int unsigned IRQ_HALF     = 1;
  localparam int unsigned IRQ_TIMEOUT  = 2;
  localparam int unsigned IRQ_OVERFLOW = 3;

  localparam int unsigned NUM_SYMBOL_WORDS = 8;
  localparam int unsigned NUM_SYMBOLS      = NUM_SYMBOL_WORDS * 16;

  localparam logic [5:0] ADDR_REG0   = 6'h00;
  localparam logic [5:0] ADDR_REG1   = 6'h04;
  localparam logic [5:0] ADDR_STATUS = 6'h08;

  localparam logic [1:0] BUS_8    = 2'b00;
  localparam logic [1:0] BUS_16   = 2'b01;
  localparam logic [1:0] BUS_32   = 2'b10;
  localparam logic [1:0] BUS_NONE = 2'b11;

  // Symbol = {segment level, segment reached its threshold}.
  function automatic logic [1:0] make_symbol(input logic       level,
                                             input logic [7:0] count,
                                             input logic [7:0] thresh);
    return {level, (count >= thresh)};
  endfunction

endpackage

// File: rtl/tqvp_hx2003_pulse_receiver_if.sv
// TinyQV peripheral data bus: register address, byte/half/word write and
// read strobes (active-low size encoding) and single-cycle read data.
interface tqvp_hx2003_pulse_receiver_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/pulse_rx_duration_counter.sv
// Prescaled, saturating 8-bit segment-duration counter.
// clr_i restarts the measurement with the current cycle as the first cycle
// of the new segment, so a segment of L cycles reads floor(L/2^p).
module pulse_rx_duration_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] prescale_i,
  output logic [7:0] count_o,
  output logic       tick_o
);

  logic [15:0] pre_q, pre_d, pre_base, mask;
  logic [7:0]  cnt_q, cnt_d, cnt_base;

  // Next prescaler/count; a clear folds into the same cycle's count step.
  always_comb begin
    mask     = 16'((32'd1 << prescale_i) - 32'd1);
    pre_base = clr_i ? '0 : pre_q;
    cnt_base = clr_i ? '0 : cnt_q;
    tick_o   = en_i && ((pre_base & mask) == mask);
    pre_d    = pre_base;
    cnt_d    = cnt_base;
    if (en_i) begin
      pre_d = tick_o ? '0 : pre_base + 16'd1;
    end
    if (tick_o && (cnt_base != 8'hFF)) begin
      cnt_d = cnt_base + 8'd1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV pulse-train receiver: measures high/low segments of a selected
// input pin and stores a 2-bit symbol per segment in a 128-symbol buffer.
// Optional 3-sample glitch filter: define PULSE_RX_GLITCH_FILTER_EN.
module tqvp_hx2003_pulse_receiver
  import pulse_rx_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         ui_in,
  output logic [7:0]                         uo_out,
  tqvp_hx2003_pulse_receiver_if.slave        bus,
  output logic                               user_interrupt
);

  rx_state_e   state_q, state_d;
  logic [3:0]  irq_status_q, irq_status_d;
  logic [3:0]  irq_enable_q, irq_enable_d;
  logic        invert_q, invert_d;
  logic        idle_q, idle_d;
  logic [31:0] reg1_q, reg1_d;
  logic [7:0]  sym_count_q, sym_count_d;
  logic [7:0]  last_dur_q, last_dur_d;
  logic        prev_q;
  logic [31:0] buf_q [NUM_SYMBOL_WORDS];

  logic        raw_in, filt_in, edge_det, running;
  logic        wr_reg0, wr_reg0_full, wr_reg1, start_req, stop_req;
  logic [3:0]  w1c, hw_set;
  logic        cnt_clr, cnt_en, tick_unused;
  logic [7:0]  count;
  logic        sym_we;
  logic [1:0]  sym_val;
  logic [31:0] rdata;

  logic [3:0]  prescale;
  logic [2:0]  in_sel;
  logic [7:0]  th_low, th_high, timeout;

  assign prescale = reg1_q[3:0];
  assign in_sel   = reg1_q[6:4];
  assign th_low   = reg1_q[15:8];
  assign th_high  = reg1_q[23:16];
  assign timeout  = reg1_q[31:24];

  assign running  = (state_q != ST_STOPPED);
  assign raw_in   = ui_in[in_sel] ^ invert_q;

`ifdef PULSE_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       hold_q;

  // Output follows the pin only once three consecutive samples agree.
  always_comb begin
    filt_in = hold_q;
    if ((raw_in == hist_q[0]) && (raw_in == hist_q[1])) begin
      filt_in = raw_in;
    end
  end

  // Sample history and held filter level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], raw_in};
      hold_q <= filt_in;
    end
  end
`else
  assign filt_in = raw_in;
`endif

  assign edge_det = (filt_in != prev_q);

  // Bus write decode.
  always_comb begin
    wr_reg0      = (bus.data_write_n != BUS_NONE) && (bus.address == ADDR_REG0);
    wr_reg0_full = wr_reg0 && (bus.data_write_n == BUS_32);
    wr_reg1      = (bus.data_write_n == BUS_32) && (bus.address == ADDR_REG1);
    w1c          = wr_reg0 ? bus.data_in[3:0] : '0;
    start_req    = wr_reg0 && bus.data_in[4];
    stop_req     = wr_reg0 && bus.data_in[5];
  end

  pulse_rx_duration_counter u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .prescale_i (prescale),
    .count_o    (count),
    .tick_o     (tick_unused)
  );

  // Capture FSM: next state, symbol emission and hardware irq events.
  always_comb begin
    state_d     = state_q;
    sym_count_d = sym_count_q;
    last_dur_d  = last_dur_q;
    hw_set      = '0;
    sym_we      = 1'b0;
    sym_val     = make_symbol(prev_q, count, prev_q ? th_high : th_low);
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (start_req && !stop_req) begin
          state_d     = ST_ARMED;
          sym_count_d = '0;
        end
      end
      ST_ARMED: begin
        if (filt_in != idle_q) begin
          cnt_clr = 1'b1;
          cnt_en  = 1'b1;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        cnt_en = 1'b1;
        // An edge takes priority over a coincident timeout.
        if (edge_det) begin
          cnt_clr = 1'b1;
          if (!sym_count_q[7]) begin
            sym_we              = 1'b1;
            sym_count_d         = sym_count_q + 8'd1;
            last_dur_d          = count;
            hw_set[IRQ_SYMBOL]  = 1'b1;
            if (sym_count_q == 8'(NUM_SYMBOLS / 2 - 1)) begin
              hw_set[IRQ_HALF] = 1'b1;
            end
            if (sym_count_q == 8'(NUM_SYMBOLS - 1)) begin
              hw_set[IRQ_OVERFLOW] = 1'b1;
              state_d              = ST_STOPPED;
            end
          end
        end else if ((prev_q == idle_q) && (timeout != '0) && (count == timeout)) begin
          hw_set[IRQ_TIMEOUT] = 1'b1;
          state_d             = ST_STOPPED;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    if (stop_req) begin
      state_d = ST_STOPPED;
    end
  end

  // Register-file next values; hardware set beats a same-cycle W1C.
  always_comb begin
    irq_status_d = (irq_status_q & ~w1c) | (hw_set & irq_enable_q);
    irq_enable_d = wr_reg0_full ? bus.data_in[11:8] : irq_enable_q;
    invert_d     = wr_reg0_full ? bus.data_in[12]   : invert_q;
    idle_d       = wr_reg0_full ? bus.data_in[13]   : idle_q;
    reg1_d       = wr_reg1      ? bus.data_in       : reg1_q;
  end

  // Control/status registers and FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_STOPPED;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      invert_q     <= 1'b0;
      idle_q       <= 1'b0;
      reg1_q       <= '0;
      sym_count_q  <= '0;
      last_dur_q   <= '0;
      prev_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
      invert_q     <= invert_d;
      idle_q       <= idle_d;
      reg1_q       <= reg1_d;
      sym_count_q  <= sym_count_d;
      last_dur_q   <= last_dur_d;
      prev_q       <= filt_in;
    end
  end

  // Symbol buffer; contents are not reset.
  always_ff @(posedge clk) begin
    if (sym_we) begin
      buf_q[sym_count_q[6:4]][{sym_count_q[3:0], 1'b0} +: 2] <= sym_val;
    end
  end

  // Read mux.
  always_comb begin
    rdata = '0;
    unique case (bus.address)
      ADDR_REG0:   rdata = {18'b0, idle_q, invert_q, irq_enable_q, 3'b0, running, irq_status_q};
      ADDR_REG1:   rdata = reg1_q;
      ADDR_STATUS: rdata = {16'b0, last_dur_q, sym_count_q};
      default: begin
        if (bus.address[5]) begin
          rdata = buf_q[bus.address[4:2]];
        end
      end
    endcase
  end

  assign bus.data_out   = (bus.data_read_n != BUS_NONE) ? rdata : '0;
  assign bus.data_ready = 1'b1;
  assign uo_out         = {4'b0, running, filt_in, 2'b0};
  assign user_interrupt = |irq_status_q;

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Self-checking bench for the pulse receiver: expected symbols are queued
// as segments are driven and compared against the buffer once stored.
module tb_tqvp_hx2003_pulse_receiver;
  import pulse_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       user_interrupt;

  tqvp_hx2003_pulse_receiver_if bus ();

  tqvp_hx2003_pulse_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [1:0]  sb_q[$];
  int unsigned sb_total;
  int unsigned sb_idx;
  int unsigned p_cur, thl_cur, thh_cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] m);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = m;
    @(posedge clk);
    #1;
    bus.data_write_n = BUS_NONE;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    bus.address     = a;
    bus.data_read_n = BUS_32;
    #1;
    d = bus.data_out;
    bus.data_read_n = BUS_NONE;
  endtask

  task automatic cfg(input int unsigned p, input int unsigned thl, input int unsigned thh,
                     input int unsigned to);
    p_cur = p; thl_cur = thl; thh_cur = thh;
    wr(ADDR_REG1, {8'(to), 8'(thh), 8'(thl), 4'(0), 4'(p)}, BUS_32);
  endtask

  task automatic start_capture();
    sb_q.delete();
    sb_total = 0;
    sb_idx   = 0;
    wr(ADDR_REG0, 32'h0000_000F, BUS_8);  // clear all irq bits
    wr(ADDR_REG0, 32'h0000_0010, BUS_8);
  endtask

  task automatic seg(input logic lvl, input int unsigned len);
    ui_in = {7'b0, lvl};
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [1:0] s);
    sb_q.push_back(s);
    sb_total++;
  endtask

  // Drive a segment and queue the symbol a reference model predicts for it.
  task automatic seg_sb(input logic lvl, input int unsigned len, output logic [1:0] s);
    int unsigned c;
    int unsigned thr;
    c   = len >> p_cur;
    if (c > 255) c = 255;
    thr = lvl ? thh_cur : thl_cur;
    s   = {lvl, (c >= thr)};
    sb_push(s);
    seg(lvl, len);
  endtask

  task automatic drain(input string tag);
    logic [31:0] st, w;
    logic [1:0]  e;
    int unsigned cnt;
    rd(ADDR_STATUS, st);
    cnt = st[7:0];
    check_eq($sformatf("%s_count", tag), st[7:0], sb_total);
    for (int unsigned i = sb_idx; i < cnt; i++) begin
      if (sb_q.size() == 0) break;
      rd({1'b1, i[6:4], 2'b00}, w);
      e = sb_q.pop_front();
      check_eq($sformatf("%s_sym%0d", tag, i), 32'(w[{i[3:0], 1'b0} +: 2]), 32'(e));
    end
    sb_idx = cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [1:0]  s;
    logic [31:0] w7_exp;

    rst_n            = 1'b0;
    ui_in            = '0;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = BUS_NONE;
    bus.data_read_n  = BUS_NONE;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_uo_out", 32'(uo_out), 32'h0);
    check_eq("rst_irq_out", 32'(user_interrupt), 32'h0);
    rd(ADDR_REG0, r);   check_eq("rst_reg0", r, 32'h0);
    rd(ADDR_REG1, r);   check_eq("rst_reg1", r, 32'h0);
    rd(ADDR_STATUS, r); check_eq("rst_status", r, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic train ending in timeout
    cfg(0, 10, 10, 30);
    rd(ADDR_REG1, r); check_eq("t1_reg1", r, 32'h1E0A_0A00);
    sb_q.delete(); sb_total = 0; sb_idx = 0;
    wr(ADDR_REG0, 32'h0000_0F10, BUS_32);
    rd(ADDR_REG0, r); check_eq("t1_running", r, 32'h0000_0F10);
    seg_sb(1'b1, 5, s);
    seg_sb(1'b0, 20, s);
    seg_sb(1'b1, 15, s);
    seg(1'b0, 40);
    rd(ADDR_REG0, r);   check_eq("t1_reg0", r, 32'h0000_0F05);
    rd(ADDR_STATUS, r); check_eq("t1_status", r, 32'h0000_0F03);
    check_eq("t1_irq_out", 32'(user_interrupt), 32'h1);
    drain("t1");

    // Prescaler 2^2
    cfg(2, 3, 3, 30);
    start_capture();
    seg_sb(1'b1, 13, s);
    seg_sb(1'b0, 11, s);
    seg_sb(1'b1, 7, s);
    seg(1'b0, 130);
    rd(ADDR_STATUS, r); check_eq("t2_status", r, 32'h0000_0103);
    rd(ADDR_REG0, r);   check_eq("t2_reg0", r, 32'h0000_0F05);
    drain("t2");

    // Saturating 600-cycle segment
    cfg(0, 10, 10, 30);
    start_capture();
    seg_sb(1'b1, 600, s);
    seg(1'b0, 40);
    rd(ADDR_STATUS, r); check_eq("t3_status", r, 32'h0000_FF01);
    drain("t3");

    // 130 segments: half-full then overflow
    start_capture();
    w7_exp = '0;
    for (int unsigned i = 0; i < 130; i++) begin
      if (i < 128) begin
        seg_sb(~i[0], 3 + (i % 4) * 4, s);
        if (i >= 112) w7_exp[(i - 112) * 2 +: 2] = s;
      end else begin
        seg(~i[0], 3 + (i % 4) * 4);
      end
      if (i == 63) begin
        rd(ADDR_REG0, r); check_eq("t4_half_before", 32'(r[1]), 32'h0);
      end
      if (i == 64) begin
        rd(ADDR_REG0, r); check_eq("t4_half_at64", 32'(r[1]), 32'h1);
      end
    end
    seg(1'b0, 40);
    rd(ADDR_REG0, r);   check_eq("t4_reg0", r, 32'h0000_0F0B);
    rd(6'h3C, r);       check_eq("t4_word7", r, w7_exp);
    drain("t4");

    // W1C of bit0 coinciding with a stored symbol
    start_capture();
    seg_sb(1'b1, 5, s);
    ui_in = 8'h00;
    wr(ADDR_REG0, 32'h0000_0001, BUS_8);
    rd(ADDR_REG0, r); check_eq("t5_w1c_race", 32'(r[3:0]), 32'h1);
    wr(ADDR_REG0, 32'h0000_0001, BUS_8);
    rd(ADDR_REG0, r); check_eq("t5_w1c_clear", 32'(r[3:0]), 32'h0);
    wr(ADDR_REG0, 32'h0000_0020, BUS_8);
    wr(ADDR_REG0, 32'h0000_0030, BUS_8);
    rd(ADDR_REG0, r); check_eq("t5_start_stop", r, 32'h0000_0F00);
    drain("t5");

    // 2-cycle glitch inside a high segment
    start_capture();
    seg(1'b1, 10);
    seg(1'b0, 2);
    seg(1'b1, 10);
    seg(1'b0, 40);
`ifdef PULSE_RX_GLITCH_FILTER_EN
    sb_push(2'd3);
`else
    sb_push(2'd3);
    sb_push(2'd0);
    sb_push(2'd3);
`endif
    drain("t6");

    // Reset during MEASURE
    start_capture();
    seg(1'b1, 5);
    seg(1'b0, 5);
    check_eq("t7_irq_before", 32'(user_interrupt), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd(ADDR_STATUS, r); check_eq("t7_status", r, 32'h0);
    check_eq("t7_irq_out", 32'(user_interrupt), 32'h0);
    check_eq("t7_running", 32'(uo_out[3]), 32'h0);
    rd(ADDR_REG1, r);   check_eq("t7_reg1", r, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
